dkong_input_ports: RTL and testbench

DKONG_INPUT_PORTS -- requirements
Module: dkong_input_ports

---
 rtl/dkong_input_ports.sv | 144 ++++++++++++++
 tb/tb_dkong_input_ports.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_input_ports.sv
// rtl/dkong_input_ports.sv - Donkey Kong IN0/IN1/IN2/DSW0 read ports with coin latch; optional DKONG_INPUT_DEBOUNCE_EN
package dkong_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic        rdn;
    logic        wrn;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module dkong_input_ports
  import dkong_bus_pkg::*;
#(
  parameter int DB_CYCLES = 1024
) (
  input  logic        masterclk,
  input  logic        rst_n,
  input  logic        ena,
  input  Z80MasterBus ibus,
  output Z80SlaveBus  obus,
  input  logic [4:0]  p1_joy,
  input  logic [4:0]  p2_joy,
  input  logic        p1_sw,
  input  logic        p2_sw,
  input  logic        coin_sw,
  input  logic [7:0]  dsw,
  output logic        coin_pending
);

  // Bit layout of the switch vector: [4:0] p1_joy, [9:5] p2_joy,
  // [10] p1_sw, [11] p2_sw, [12] coin_sw, [20:13] dsw (not debounced).
  localparam int NSW  = 13;
  localparam int COIN = 12;

  logic [20:0]    raw_sw;
  logic [20:0]    sync1;
  logic [20:0]    sync2;
  logic [NSW-1:0] db;

  assign raw_sw = {dsw, coin_sw, p2_sw, p1_sw, p2_joy, p1_joy};

  // Two-flop synchronizer for every asynchronous switch input
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_sw;
      sync2 <= sync1;
    end
  end

`ifdef DKONG_INPUT_DEBOUNCE_EN
  localparam int              CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < NSW; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          db_q;

    // Accept a new level only after it has differed for DB_CYCLES straight cycles
    always_ff @(posedge masterclk) begin
      if (!rst_n) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (sync2[i] == db_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_q <= sync2[i];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign db[i] = db_q;
  end
`else
  assign db = sync2[NSW-1:0];
`endif

  logic       coin_prev;
  logic       coin_latch;
  logic       rd_in2_q;
  logic       rd_act;
  logic       coin_rise;
  logic       rd_done;
  logic [7:0] port_data;
  logic [7:0] dslave_q;

  assign rd_act    = ena & ~ibus.rdn;
  assign coin_rise = db[COIN] & ~coin_prev;
  // An IN2 read completes when rdn returns high after a selected low cycle
  assign rd_done   = rd_in2_q & ibus.rdn;

  // Coin edge detect and latch; a new coin beats a simultaneous read clear
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      coin_prev  <= 1'b0;
      coin_latch <= 1'b0;
      rd_in2_q   <= 1'b0;
    end else begin
      coin_prev <= db[COIN];
      rd_in2_q  <= rd_act & (ibus.addr[8:7] == 2'b10);
      if (coin_rise) begin
        coin_latch <= 1'b1;
      end else if (rd_done) begin
        coin_latch <= 1'b0;
      end
    end
  end

  // Port select on addr[8:7]; every mirror in the window answers
  always_comb begin
    port_data = 8'h00;
    case (ibus.addr[8:7])
      2'b00:   port_data = {3'b000, db[4:0]};
      2'b01:   port_data = {3'b000, db[9:5]};
      2'b10:   port_data = {coin_latch, 3'b000, db[11], db[10], 2'b00};
      default: port_data = sync2[20:13];
    endcase
  end

  // Read data register, updated only during a selected read
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      dslave_q <= 8'h00;
    end else if (rd_act) begin
      dslave_q <= port_data;
    end
  end

  assign obus         = '{dslave: dslave_q, mwait: 1'b1};
  assign coin_pending = coin_latch;

  // Upper address bits and wrn are part of the shared bus but do not affect this block
  logic unused_bus;
  assign unused_bus = ^{ibus.addr[15:9], ibus.addr[6:0], ibus.wrn};

endmodule

// File: tb/tb_dkong_input_ports.sv
// tb/tb_dkong_input_ports.sv - randomized and directed bench for dkong_input_ports against a history-based model
module tb_dkong_input_ports;
  import dkong_bus_pkg::*;

  localparam int DBC = 8;
`ifdef DKONG_INPUT_DEBOUNCE_EN
  localparam int DEPTH = DBC;
`else
  localparam int DEPTH = 0;
`endif

  logic        masterclk = 1'b0;
  logic        rst_n;
  logic        ena;
  Z80MasterBus ibus;
  Z80SlaveBus  obus;
  logic [4:0]  p1_joy;
  logic [4:0]  p2_joy;
  logic        p1_sw;
  logic        p2_sw;
  logic        coin_sw;
  logic [7:0]  dsw;
  logic        coin_pending;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rd_data;

  always #5 masterclk = ~masterclk;

  dkong_input_ports #(.DB_CYCLES(DBC)) dut (
    .masterclk    (masterclk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ibus         (ibus),
    .obus         (obus),
    .p1_joy       (p1_joy),
    .p2_joy       (p2_joy),
    .p1_sw        (p1_sw),
    .p2_sw        (p2_sw),
    .coin_sw      (coin_sw),
    .dsw          (dsw),
    .coin_pending (coin_pending)
  );

  // Reference model: the level seen by the debouncers is the input two edges
  // late; a switch flips once its last DEPTH seen samples all disagree with it.
  logic [20:0] m_pipe[$];
  logic [12:0] m_hist[$];
  logic [12:0] m_db;
  logic        m_prev;
  logic        m_latch;
  logic        m_rd;
  logic [7:0]  m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back(21'd0);
    m_pipe.push_back(21'd0);
    m_hist.delete();
    m_db    = '0;
    m_prev  = 1'b0;
    m_latch = 1'b0;
    m_rd    = 1'b0;
    m_dout  = 8'h00;
  endtask

  task automatic model_step();
    logic [20:0] raw;
    logic [20:0] seen;
    logic [7:0]  port;
    logic        rise;
    logic        done;
    bit          flip;
    raw  = {dsw, coin_sw, p2_sw, p1_sw, p2_joy, p1_joy};
    seen = m_pipe.pop_front();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_pipe.push_back(raw);
    if (DEPTH == 0) m_db = seen[12:0];
    case (ibus.addr[8:7])
      2'b00:   port = {3'b000, m_db[4:0]};
      2'b01:   port = {3'b000, m_db[9:5]};
      2'b10:   port = {m_latch, 3'b000, m_db[11], m_db[10], 2'b00};
      default: port = seen[20:13];
    endcase
    rise   = m_db[12] && !m_prev;
    done   = m_rd && ibus.rdn;
    m_prev = m_db[12];
    if (ena && !ibus.rdn) m_dout = port;
    m_rd = ena && !ibus.rdn && (ibus.addr[8:7] == 2'b10);
    if (rise) m_latch = 1'b1;
    else if (done) m_latch = 1'b0;
    if (DEPTH > 0) begin
      m_hist.push_back(seen[12:0]);
      if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
      if (m_hist.size() == DEPTH) begin
        for (int b = 0; b < 13; b++) begin
          flip = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_db[b]) flip = 1'b0;
          if (flip) m_db[b] = ~m_db[b];
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge masterclk);
      model_step();
      @(negedge masterclk);
      chk("dslave", obus.dslave, m_dout);
      chk("coin_pending", coin_pending, m_latch);
      chk("mwait", obus.mwait, 1);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    ena       = 1'b1;
    ibus.addr = a;
    ibus.rdn  = 1'b0;
    tick(1);
    d        = obus.dslave;
    ibus.rdn = 1'b1;
    tick(1);
    ena = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    ibus    = '{addr: 16'h7C00, rdn: 1'b1, wrn: 1'b1};
    p1_joy  = '0;
    p2_joy  = '0;
    p1_sw   = 1'b0;
    p2_sw   = 1'b0;
    coin_sw = 1'b0;
    dsw     = 8'h00;
    model_reset();
    @(negedge masterclk);
    tick(3);
    chk("rst_dslave", obus.dslave, 8'h00);
    chk("rst_coin", coin_pending, 0);
    rst_n = 1'b1;

    p1_joy = 5'b00001;
    tick(12);
    bus_read(16'h7C00, rd_data);
    chk("joy_in0", rd_data, 8'h01);

    p2_sw = 1'b1;
    tick(4);
    p2_sw = 1'b0;
    tick(8);
    bus_read(16'h7D00, rd_data);
    chk("glitch_in2", rd_data, 8'h00);
    p2_sw = 1'b1;
    tick(12);
    bus_read(16'h7D00, rd_data);
    chk("p2sw_in2", rd_data, 8'h08);

    p2_sw   = 1'b0;
    coin_sw = 1'b1;
    tick(12);
    bus_read(16'h7D00, rd_data);
    chk("coin_first", rd_data, 8'h80);
    chk("coin_cleared", coin_pending, 0);
    bus_read(16'h7D00, rd_data);
    chk("coin_second", rd_data, 8'h00);

    dsw = 8'h80;
    tick(3);
    bus_read(16'h7D80, rd_data);
    chk("dsw_7d80", rd_data, 8'h80);
    bus_read(16'h7DFF, rd_data);
    chk("dsw_7dff", rd_data, 8'h80);
    ena       = 1'b1;
    ibus.addr = 16'h7C00;
    ibus.wrn  = 1'b0;
    tick(1);
    ibus.wrn = 1'b1;
    ena      = 1'b0;
    tick(1);
    chk("write_hold", obus.dslave, 8'h80);
    bus_read(16'h7C00, rd_data);
    chk("write_in0", rd_data, 8'h01);

    coin_sw = 1'b0;
    tick(12);
    coin_sw = 1'b1;
    tick(9);
    ena       = 1'b1;
    ibus.addr = 16'h7D00;
    ibus.rdn  = 1'b0;
    tick(1);
    ibus.rdn = 1'b1;
    tick(1);
    ena = 1'b0;
    chk("set_beats_clear", coin_pending, (DEPTH > 0) ? 1 : 0);

    bus_read(16'h7D00, rd_data);
    coin_sw = 1'b0;
    tick(12);
    coin_sw = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_dslave", obus.dslave, 8'h00);
    chk("midrst_coin", coin_pending, 0);
    tick(8);
    chk("restart_count", coin_pending, (DEPTH == 0) ? 1 : 0);
    tick(4);
    bus_read(16'h7D00, rd_data);
    chk("restart_coin", rd_data, 8'h80);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) p1_joy = p1_joy ^ 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) p2_joy = p2_joy ^ 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 11) == 0) p1_sw = ~p1_sw;
      if ($urandom_range(0, 11) == 0) p2_sw = ~p2_sw;
      if ($urandom_range(0, 9) == 0) coin_sw = ~coin_sw;
      if ($urandom_range(0, 63) == 0) dsw = 8'($urandom);
      rst_n     = ($urandom_range(0, 249) != 0);
      ena       = ($urandom_range(0, 3) != 0);
      ibus.addr = 16'h7C00 | 16'($urandom_range(0, 511));
      ibus.rdn  = 1'($urandom_range(0, 1));
      ibus.wrn  = 1'($urandom_range(0, 1));
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
